cg_phase_sequencer: RTL

Top-level phase sequencer for one conjugate-gradient solve. It sits directly upstream of the memory-address control unit and drives that unit's phase strobes: `start`, `reset_vXv1`, `read_again`, `read_again_2` and `iteration_counter_enable`. It advances through the mXv, vXv, alpha, x/r-update, beta and p-update phases by watching the datapath finish and write strobes, and counts iterations up to a fixed limit. A watchdog aborts a run if any phase stalls.

---
 rtl/cg_phase_sequencer_if.sv | 35 +++
 rtl/cg_phase_sequencer.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/cg_phase_sequencer_if.sv
// Phase-strobe and completion handshake between the CG phase sequencer (master)
// and the datapath / memory-address control side (slave).
interface cg_phase_sequencer_if;
    logic        start_request;
    logic        mXv1_finish;
    logic        vXv1_finish;
    logic        finish_alpha;
    logic        finish_alu;
    logic        result_mem_we_4;
    logic        result_mem_we_5;
    logic        result_mem_we_6;
    logic        start;
    logic        reset_vXv1;
    logic        read_again;
    logic        read_again_2;
    logic        iteration_counter_enable;
    logic [10:0] iteration_count;
    logic [2:0]  phase;
    logic        cg_done;
    logic        error;

    modport master (
        input  start_request, mXv1_finish, vXv1_finish, finish_alpha, finish_alu,
        input  result_mem_we_4, result_mem_we_5, result_mem_we_6,
        output start, reset_vXv1, read_again, read_again_2, iteration_counter_enable,
        output iteration_count, phase, cg_done, error
    );

    modport slave (
        output start_request, mXv1_finish, vXv1_finish, finish_alpha, finish_alu,
        output result_mem_we_4, result_mem_we_5, result_mem_we_6,
        input  start, reset_vXv1, read_again, read_again_2, iteration_counter_enable,
        input  iteration_count, phase, cg_done, error
    );
endinterface

// File: rtl/cg_phase_sequencer.sv
// Phase sequencer for one conjugate-gradient solve: steps mXv/vXv/alpha/x-r/beta/p
// phases, paces per-word reads on write strobes, counts iterations, and watchdogs stalls.
module cg_phase_sequencer #(
    parameter int no_of_units                     = 8,
    parameter int number_of_equations_per_cluster = 19,
    parameter int additional = no_of_units - (number_of_equations_per_cluster % no_of_units),
    parameter int total      = number_of_equations_per_cluster + additional,
    parameter int words      = total / no_of_units,
    parameter int no_of_iteration                 = 20,
    parameter int timeout_cycles                  = 4096
) (
    input  logic                 clk,
    input  logic                 reset,
    cg_phase_sequencer_if.master bus
);
    typedef enum logic [2:0] {
        IDLE  = 3'd0, MXV  = 3'd1, VXV  = 3'd2, ALPHA = 3'd3,
        XR    = 3'd4, BETA = 3'd5, PUPD = 3'd6, DONE  = 3'd7
    } state_t;

    localparam int WORD_W = (words > 1) ? $clog2(words) : 1;
    localparam int WD_W   = $clog2(timeout_cycles + 1);
    localparam logic [WORD_W-1:0] LAST_WORD  = WORD_W'(words - 1);
    localparam logic [WD_W-1:0]   WD_LIMIT   = WD_W'(timeout_cycles - 1);
    localparam logic [10:0]       ITER_LIMIT = 11'(no_of_iteration);

    state_t            state_reg, state_next;
    logic [WORD_W-1:0] word_cnt_reg, word_cnt_next;
    logic [1:0]        seen_reg, seen_next;
    logic [WD_W-1:0]   wd_cnt_reg, wd_cnt_next;
    logic [10:0]       iter_cnt_reg, iter_cnt_next;
    logic              error_reg, error_next;
    logic              start_reg, start_next;
    logic              reset_vxv1_reg, reset_vxv1_next;
    logic              read_again_reg, read_again_next;
    logic              read_again_2_reg, read_again_2_next;
    logic              ice_reg, ice_next;
    logic              cg_done_reg, cg_done_next;

    logic       strobe_ok;
    logic [1:0] hit, need, seen_now;
    logic       word_ready, word_done, iter_end;

    // Strobes landing in the cycle of their own read pulse belong to the previous slot.
    assign strobe_ok = !(read_again_reg || read_again_2_reg);
    assign hit[0]    = strobe_ok && ((state_reg == XR   && bus.result_mem_we_4) ||
                                     (state_reg == PUPD && bus.result_mem_we_6));
    assign hit[1]    = strobe_ok && (state_reg == XR) && bus.result_mem_we_5;
    assign need      = {state_reg == XR, 1'b1};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_seen
            assign seen_now[gi] = seen_reg[gi] | hit[gi] | ~need[gi];
        end
    endgenerate

    assign word_ready = &seen_now;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg        <= IDLE;
            word_cnt_reg     <= '0;
            seen_reg         <= '0;
            wd_cnt_reg       <= '0;
            iter_cnt_reg     <= '0;
            error_reg        <= 1'b0;
            start_reg        <= 1'b0;
            reset_vxv1_reg   <= 1'b1;
            read_again_reg   <= 1'b0;
            read_again_2_reg <= 1'b0;
            ice_reg          <= 1'b0;
            cg_done_reg      <= 1'b0;
        end else begin
            state_reg        <= state_next;
            word_cnt_reg     <= word_cnt_next;
            seen_reg         <= seen_next;
            wd_cnt_reg       <= wd_cnt_next;
            iter_cnt_reg     <= iter_cnt_next;
            error_reg        <= error_next;
            start_reg        <= start_next;
            reset_vxv1_reg   <= reset_vxv1_next;
            read_again_reg   <= read_again_next;
            read_again_2_reg <= read_again_2_next;
            ice_reg          <= ice_next;
            cg_done_reg      <= cg_done_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        word_cnt_next = word_cnt_reg;
        seen_next     = seen_reg;
        wd_cnt_next   = wd_cnt_reg;
        iter_cnt_next = iter_cnt_reg;
        error_next    = error_reg;
        word_done     = 1'b0;
        iter_end      = 1'b0;
        case (state_reg)
            IDLE, DONE: if (bus.start_request) begin
                state_next    = MXV;
                iter_cnt_next = '0;
                error_next    = 1'b0;
            end
            MXV:   if (bus.mXv1_finish)  state_next = VXV;
            VXV:   if (bus.vXv1_finish)  state_next = ALPHA;
            ALPHA: if (bus.finish_alpha) state_next = XR;
            BETA:  if (bus.finish_alu)   state_next = PUPD;
            XR, PUPD: begin
                if (word_ready) begin
                    word_done = 1'b1;
                    seen_next = '0;
                    if (word_cnt_reg == LAST_WORD) begin
                        word_cnt_next = '0;
                        if (state_reg == XR) begin
                            state_next = BETA;
                        end else begin
                            iter_end      = 1'b1;
                            iter_cnt_next = iter_cnt_reg + 11'd1;
                            state_next    = (iter_cnt_reg + 11'd1 == ITER_LIMIT) ? DONE : MXV;
                        end
                    end else begin
                        word_cnt_next = word_cnt_reg + 1'b1;
                    end
                end else begin
                    seen_next = seen_now & need;
                end
            end
            default: ;
        endcase

        // Watchdog only expires when nothing moved this cycle.
        if (state_next != state_reg || (|hit)) begin
            wd_cnt_next = '0;
        end else if (state_reg != IDLE && state_reg != DONE) begin
            if (wd_cnt_reg == WD_LIMIT) begin
                error_next  = 1'b1;
                state_next  = DONE;
                wd_cnt_next = '0;
            end else begin
                wd_cnt_next = wd_cnt_reg + 1'b1;
            end
        end else begin
            wd_cnt_next = '0;
        end

        if (state_next != state_reg) begin
            word_cnt_next = '0;
            seen_next     = '0;
        end
    end

    always_comb begin
        start_next        = (state_next == MXV);
        reset_vxv1_next   = (state_next != VXV);
        read_again_next   = (state_next == XR)   && (state_reg != XR   || word_done);
        read_again_2_next = (state_next == PUPD) && (state_reg != PUPD || word_done);
        ice_next          = iter_end;
        cg_done_next      = (state_next == DONE);
    end

    assign bus.start                    = start_reg;
    assign bus.reset_vXv1               = reset_vxv1_reg;
    assign bus.read_again               = read_again_reg;
    assign bus.read_again_2             = read_again_2_reg;
    assign bus.iteration_counter_enable = ice_reg;
    assign bus.iteration_count          = iter_cnt_reg;
    assign bus.phase                    = state_reg;
    assign bus.cg_done                  = cg_done_reg;
    assign bus.error                    = error_reg;
endmodule
